// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment driver: snapshots the nibble bus once per frame and scans one digit per slot.
// Each slot opens with a dead time so no two digits are ever visible back to back; outputs are registered.
module seg7_scan_driver #(
  parameter int DIGITS        = 4,
  parameter int FREQ          = 27_000_000,
  parameter int REFRESH_HZ    = 1000,
  parameter int DEAD_CYCLES   = 16,
  parameter int ACTIVE_LOW    = 0,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_number,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_digit_sel,
  output logic                  o_frame
);

  localparam int TICKS  = FREQ / REFRESH_HZ;
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
  localparam logic [TICK_W-1:0] DEAD_END  = TICK_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] SEL_OFF   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frame_q, frame_d;

  logic                scan_start;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   lead_zero;
  logic                run_zero;
  logic                digit_blank;
  logic                phase_on;
  logic [DIGITS-1:0]   sel_raw;
  logic [6:0]          seg_raw;

  always_comb begin
    scan_start = (tick_q == '0) && (idx_q == '0);

    tick_d = tick_q + 1'b1;
    idx_d  = idx_q;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    snap_d = scan_start ? i_number : snap_q;

    // lead_zero[k]: nibbles k..DIGITS-1 of the snapshot are all zero
    lead_zero = '0;
    run_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run_zero     = run_zero && (snap_q[4*k +: 4] == 4'h0);
      lead_zero[k] = run_zero;
    end

    nibble      = snap_q[{idx_q, 2'b00} +: 4];
    digit_blank = (BLANK_LEADING != 0) && (idx_q != '0) && lead_zero[idx_q];
    phase_on    = (tick_q >= DEAD_END) && !digit_blank;

    sel_raw = '0;
    if (phase_on) begin
      sel_raw[idx_q] = 1'b1;
    end
    seg_raw = phase_on ? hex_to_seg(nibble) : 7'h00;

    sel_d   = sel_raw ^ SEL_OFF;
    seg_d   = seg_raw ^ SEG_OFF;
    frame_d = scan_start;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
      frame_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  assign o_seg       = seg_q;
  assign o_digit_sel = sel_q;
  assign o_frame     = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed and randomised checks of seg7_scan_driver with TICKS=10, DEAD_CYCLES=2, DIGITS=4.
// Three instances cover plain, leading-zero-blanked and common-anode configurations.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] num_a = 16'h0;
  logic [15:0] num_b = 16'h0;
  logic [15:0] num_c = 16'h0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] sel_a, sel_b, sel_c;
  logic       frm_a, frm_b, frm_c;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .FREQ(1000), .REFRESH_HZ(100), .DEAD_CYCLES(2),
                     .ACTIVE_LOW(0), .BLANK_LEADING(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_number(num_a),
    .o_seg(seg_a), .o_digit_sel(sel_a), .o_frame(frm_a));

  seg7_scan_driver #(.DIGITS(4), .FREQ(1000), .REFRESH_HZ(100), .DEAD_CYCLES(2),
                     .ACTIVE_LOW(0), .BLANK_LEADING(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_number(num_b),
    .o_seg(seg_b), .o_digit_sel(sel_b), .o_frame(frm_b));

  seg7_scan_driver #(.DIGITS(4), .FREQ(1000), .REFRESH_HZ(100), .DEAD_CYCLES(2),
                     .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_number(num_c),
    .o_seg(seg_c), .o_digit_sel(sel_c), .o_frame(frm_c));

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Expected {frame, sel, seg} on cycle c after release; tbl holds each digit's pattern, lit masks blanked digits.
  function automatic logic [11:0] exp_out(input int c, input logic [27:0] tbl, input logic [3:0] lit);
    int         slot, d, t;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       fr;
    sel = 4'h0;
    seg = 7'h00;
    fr  = 1'b0;
    if (c >= 1) begin
      slot = (c - 1) % 40;
      d    = slot / 10;
      t    = slot % 10;
      fr   = (slot == 0);
      if (t >= 2 && lit[d]) begin
        sel = 4'b0001 << d;
        seg = tbl[d*7 +: 7];
      end
    end
    return {fr, sel, seg};
  endfunction

  // Holds reset for a few cycles checking idle outputs, then leaves the bench at cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("rst_a", {20'h0, frm_a, sel_a, seg_a}, 32'h0);
      check_vec("rst_c", {21'h0, sel_c, seg_c}, {21'h0, 4'hF, 7'h7F});
      check_vec("rst_frm_c", {31'h0, frm_c}, 32'h0);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] e;
    logic [15:0] exp_snap;
    int          zeros, last, d, cc;

    // Plain scan, leading-zero blanking, common-anode inversion
    num_a = 16'h12A0;
    num_b = 16'h0005;
    num_c = 16'h0008;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      e = exp_out(c, {7'h06, 7'h5B, 7'h77, 7'h3F}, 4'hF);
      check_vec($sformatf("scan_a c%0d", c), {20'h0, frm_a, sel_a, seg_a}, {20'h0, e});
      e = exp_out(c, {4{7'h6D}}, 4'b0001);
      check_vec($sformatf("blank_b c%0d", c), {20'h0, frm_b, sel_b, seg_b}, {20'h0, e});
      e = exp_out(c, {4{7'h7F}}, 4'b0001);
      check_vec($sformatf("alow_c c%0d", c), {21'h0, sel_c, seg_c}, {21'h0, ~e[10:7], ~e[6:0]});
      @(negedge clk);
    end

    // Mid-frame input change is deferred to the next capture; all-zero value shows a single 0
    num_a = 16'h1111;
    num_b = 16'h0000;
    do_reset();
    for (int c = 0; c < 85; c++) begin
      e = exp_out(c, (c <= 41) ? {4{7'h06}} : {4{7'h5B}}, 4'hF);
      check_vec($sformatf("snap_a c%0d", c), {20'h0, frm_a, sel_a, seg_a}, {20'h0, e});
      e = exp_out(c, {4{7'h3F}}, 4'b0001);
      check_vec($sformatf("zero_b c%0d", c), {20'h0, frm_b, sel_b, seg_b}, {20'h0, e});
      if (c == 15) num_a = 16'h2222;
      @(negedge clk);
    end

    // One-cycle reset in the middle of digit 2
    num_a = 16'h12A0;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      cc = (c <= 25) ? c : c - 26;
      e  = exp_out(cc, {7'h06, 7'h5B, 7'h77, 7'h3F}, 4'hF);
      check_vec($sformatf("mrst_a c%0d", c), {20'h0, frm_a, sel_a, seg_a}, {20'h0, e});
      rst = (c == 25);
      @(negedge clk);
    end

    // Random values over 20 frames against a capture scoreboard
    num_a    = 16'($urandom);
    do_reset();
    exp_snap = 16'h0;
    zeros    = 0;
    last     = -1;
    for (int c = 0; c < 20 * 40 + 3; c++) begin
      e = exp_out(c, 28'h0, 4'h0);
      check_vec($sformatf("rfrm c%0d", c), {31'h0, frm_a}, {31'h0, e[11]});
      if (frm_a) exp_snap = num_a;
      check_vec($sformatf("onehot c%0d", c), {31'h0, ($countones(sel_a) <= 1)}, 32'h1);
      if (sel_a == 4'h0) begin
        check_vec($sformatf("rdark c%0d", c), {25'h0, seg_a}, 32'h0);
        zeros++;
      end else begin
        d = 0;
        for (int k = 0; k < 4; k++) if (sel_a[k]) d = k;
        if (last >= 0 && d != last)
          check_vec($sformatf("dead c%0d", c), {31'h0, (zeros >= 2)}, 32'h1);
        check_vec($sformatf("rseg c%0d", c), {25'h0, seg_a}, {25'h0, seg_of(exp_snap[d*4 +: 4])});
        last  = d;
        zeros = 0;
      end
      if ($urandom_range(3) == 0) num_a = 16'($urandom);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
